// File: rtl/mult_div_pkg.sv
// mult_div_pkg -- shared definitions for the iterative multiply/divide unit.
//   OP_*        : 2-bit operation encoding driven by the control unit
//   md_state_t  : sequencer state (IDLE, RUN, FIX)
//   op_is_div() : true for DIV/DIVU (op[0] selects divide)
// Optional build macro UNSIGNED_MD_EN (see mult_div_unit) gives op[1] meaning.
package mult_div_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_DIV   = 2'b01;
  localparam logic [1:0] OP_MULTU = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/mult_div_if.sv
// mult_div_if -- control-unit <-> mult_div_unit connection.
//   start, op, a, b         : request side (control unit drives)
//   busy, done, div_zero,
//   hi, lo                  : response side (mult/div unit drives)
// Handshake: start is sampled only while the unit is idle (busy low and no
// divide-by-zero response pending); a start seen while busy is dropped, not
// queued. Operands are captured on the accepting edge and may change after it.
// done is a one-cycle pulse marking hi/lo valid; div_zero pulses together with
// done for a divide by zero (hi/lo untouched). A new start may be issued in the
// same cycle done is high.
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_step.sv
// md_step -- one combinational iteration of the iterative multiply/divide.
//   i_acc  : 2*WIDTH accumulator. Multiply: {partial product, remaining
//            multiplier bits}. Divide: {partial remainder, remaining dividend
//            bits / quotient bits shifted in so far}.
//   i_opnd : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   i_div  : 1 = restoring-divide step, 0 = shift-add multiply step
//   o_acc  : next accumulator; in divide mode bit 0 is left 0 for the caller
//            to fill with o_qbit
//   o_qbit : quotient bit produced by this divide step (0 when multiplying)
module md_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  input  logic               i_div,
  output logic [2*WIDTH-1:0] o_acc,
  output logic               o_qbit
);

  logic [WIDTH:0] w_addend;
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_prem;
  logic [WIDTH:0] w_diff;

  always_comb begin
    w_addend = '0;
    w_sum    = '0;
    w_prem   = '0;
    w_diff   = '0;
    o_qbit   = 1'b0;
    o_acc    = i_acc;

    // Multiply: add the multiplicand when the current multiplier LSB is set,
    // then shift the whole accumulator right; the carry lands in the MSB.
    w_addend = i_acc[0] ? {1'b0, i_opnd} : '0;
    w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + w_addend;

    // Divide: WIDTH+1-bit partial remainder = remainder shifted left with the
    // next dividend bit. A clear borrow bit means the divisor fits.
    w_prem = i_acc[2*WIDTH-1:WIDTH-1];
    w_diff = w_prem - {1'b0, i_opnd};

    if (i_div) begin
      o_qbit = ~w_diff[WIDTH];
      o_acc  = {(o_qbit ? w_diff[WIDTH-1:0] : w_prem[WIDTH-1:0]),
                i_acc[WIDTH-2:0], 1'b0};
    end else begin
      o_acc  = {w_sum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit -- iterative radix-2 multiply / restoring divide for the
// multicycle MIPS datapath, writing the HI/LO pair.
//   clock       : rising-edge clock
//   reset       : asynchronous reset, active low
//   bus         : mult_div_if slave modport (start/op/a/b in,
//                 busy/done/div_zero/hi/lo out)
//   o_dbg_state : current sequencer state, for observation only
// Parameter WIDTH (>= 4, even): operand and HI/LO width.
// Build macro UNSIGNED_MD_EN: when defined, op[1] selects unsigned MULTU/DIVU;
// when undefined op[1] is ignored and every operation is signed.
// Latency: start accepted at edge E0, hi/lo/done updated at edge E(WIDTH+1).
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clock,
  input  logic      reset,
  mult_div_if.slave bus,
  output md_state_t o_dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  md_state_t            r_state;
  md_state_t            w_next_state;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opnd;
  logic [CW-1:0]        r_cnt;
  logic                 r_div;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_dz;
  logic                 r_dz_pend;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_unsigned;
  logic                 w_is_div;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic                 w_accept;
  logic                 w_dz;
  logic                 w_go;
  logic                 w_last;
  logic [2*WIDTH-1:0]   w_step_acc;
  logic                 w_qbit;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quot;
  logic [WIDTH-1:0]     w_rem;
  logic [WIDTH-1:0]     w_res_hi;
  logic [WIDTH-1:0]     w_res_lo;

`ifdef UNSIGNED_MD_EN
  assign w_unsigned = bus.op[1];
`else
  assign w_unsigned = 1'b0;
`endif

  // Operand preprocessing: magnitudes plus sign bits. For unsigned ops the
  // sign bits are forced low, which also disables the FIX negation.
  assign w_is_div = op_is_div(bus.op);
  assign w_a_neg  = ~w_unsigned & bus.a[WIDTH-1];
  assign w_b_neg  = ~w_unsigned & bus.b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (-bus.a) : bus.a;
  assign w_b_mag  = w_b_neg ? (-bus.b) : bus.b;

  // A pending divide-by-zero response keeps the unit closed for one cycle
  // even though it never leaves IDLE.
  assign w_accept = (r_state == IDLE) && bus.start && !r_dz_pend;
  assign w_dz     = w_accept && w_is_div && (bus.b == '0);
  assign w_go     = w_accept && !w_dz;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  md_step #(.WIDTH(WIDTH)) u_step (
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .i_div  (r_div),
    .o_acc  (w_step_acc),
    .o_qbit (w_qbit)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and FIX-stage sign correction.
  always_comb begin
    w_next_state = r_state;
    w_prod       = r_acc;
    w_quot       = r_acc[WIDTH-1:0];
    w_rem        = r_acc[2*WIDTH-1:WIDTH];
    w_res_hi     = '0;
    w_res_lo     = '0;

    case (r_state)
      IDLE:    if (w_go) w_next_state = RUN;
      RUN:     if (w_last) w_next_state = FIX;
      FIX:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase

    if (r_div) begin
      // Quotient sign = sign(a) xor sign(b); remainder follows the dividend.
      // The most-negative / -1 case yields quotient magnitude 2^(WIDTH-1),
      // which already reads back as the most-negative value.
      w_res_lo = r_neg_q ? (-w_quot) : w_quot;
      w_res_hi = r_neg_r ? (-w_rem)  : w_rem;
    end else begin
      if (r_neg_q) w_prod = -r_acc;
      {w_res_hi, w_res_lo} = w_prod;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_acc     <= '0;
      r_opnd    <= '0;
      r_cnt     <= '0;
      r_div     <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
      r_dz_pend <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
      r_dz_pend <= w_dz;
      if (r_dz_pend) begin
        r_done <= 1'b1;
        r_dz   <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_go) begin
            r_div   <= w_is_div;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            // Multiply iterates over the multiplier (b); divide shifts the
            // dividend (a) through the low half.
            r_opnd  <= w_is_div ? w_b_mag : w_a_mag;
            r_acc   <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          r_acc <= {w_step_acc[2*WIDTH-1:1], w_step_acc[0] | w_qbit};
          r_cnt <= r_cnt + CW'(1);
        end
        FIX: begin
          r_hi   <= w_res_hi;
          r_lo   <= w_res_lo;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.div_zero = r_dz;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit -- directed self-checking bench for mult_div_unit, WIDTH=32.
// Expected results are hand-computed and queued in exp_q before each request.
module tb_mult_div_unit;
  import mult_div_pkg::*;

  localparam int W       = 32;
  localparam int LAT     = W + 1;
  localparam int TIMEOUT = 100;

  logic      clock;
  logic      reset;
  md_state_t dbg_state;

  mult_div_if #(.WIDTH(W)) bus_if ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus_if),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [2*W-1:0] got,
                       input logic [2*W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a request for one edge (E0), then scramble the operands to show
  // they are captured on the accepting edge.
  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
    bus_if.start = 1'b1;
    bus_if.op    = op;
    bus_if.a     = a;
    bus_if.b     = b;
    tick();
    bus_if.start = 1'b0;
    bus_if.a     = $urandom;
    bus_if.b     = $urandom;
  endtask

  // Counts edges after E0 until done is seen (bounded).
  task automatic wait_done(output int edges);
    edges = 0;
    while (edges < TIMEOUT) begin
      tick();
      edges++;
      if (bus_if.done) break;
    end
  endtask

  task automatic compare_result(input string tag);
    logic [2*W-1:0] exp;
    if (exp_q.size() == 0) begin
      check({tag, "_noexp"}, 1'b1, 1'b0);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_hilo"}, {bus_if.hi, bus_if.lo}, exp);
    end
  endtask

  // Full operation; leaves the bench in the cycle where done is high.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int edges;
    exp_q.push_back({ehi, elo});
    start_op(op, a, b);
    check({tag, "_busy"}, bus_if.busy, 1'b1);
    wait_done(edges);
    check({tag, "_lat"}, edges, LAT);
    check({tag, "_dz"}, bus_if.div_zero, 1'b0);
    compare_result(tag);
  endtask

  task automatic run_op_idle(input string tag, input logic [1:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] ehi, input logic [W-1:0] elo);
    run_op(tag, op, a, b, ehi, elo);
    tick();
    check({tag, "_done_pulse"}, bus_if.done, 1'b0);
    check({tag, "_busy_end"}, bus_if.busy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int edges;
    int n_done;
    int first_done;

    reset        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.op    = OP_MULT;
    bus_if.a     = '0;
    bus_if.b     = '0;
    tick();
    tick();
    check("rst_busy",  bus_if.busy, 1'b0);
    check("rst_done",  bus_if.done, 1'b0);
    check("rst_dz",    bus_if.div_zero, 1'b0);
    check("rst_hilo",  {bus_if.hi, bus_if.lo}, '0);
    check("rst_state", dbg_state, IDLE);
    reset = 1'b1;
    tick();

    // Signed multiply / divide vectors.
    run_op_idle("mult_7_m3", OP_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op_idle("mult_m2_m3", OP_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0, 32'h6);
    run_op_idle("mult_minsq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
`ifdef UNSIGNED_MD_EN
    run_op_idle("multu_ff", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1);
    run_op_idle("divu_big", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h1, 32'h7FFF_FFFC);
`else
    run_op_idle("multu_ff", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
    run_op_idle("divu_big", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
`endif
    run_op_idle("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op_idle("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op_idle("div_100_m7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2);
    run_op_idle("div_m100_7", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2);

    // Preload hi/lo = 0x11/0x22 (0x2211 / 0x100), then divide by zero.
    run_op_idle("preload", OP_DIV, 32'h2211, 32'h100, 32'h11, 32'h22);
    start_op(OP_DIV, 32'd5, 32'd0);
    check("dz_e0_done", bus_if.done, 1'b0);
    check("dz_e0_busy", bus_if.busy, 1'b0);
    tick();
    check("dz_e1_done", bus_if.done, 1'b1);
    check("dz_e1_flag", bus_if.div_zero, 1'b1);
    check("dz_e1_busy", bus_if.busy, 1'b0);
    check("dz_hilo", {bus_if.hi, bus_if.lo}, {32'h11, 32'h22});
    tick();
    check("dz_e2_done", bus_if.done, 1'b0);
    check("dz_e2_flag", bus_if.div_zero, 1'b0);

    // start pulsed at edge 10 of a running MULT must be ignored.
    exp_q.push_back({32'h0, 32'd56088});
    start_op(OP_MULT, 32'd123, 32'd456);
    n_done     = 0;
    first_done = 0;
    for (int k = 1; k <= LAT + 20; k++) begin
      if (k == 10) begin
        bus_if.start = 1'b1;
        bus_if.op    = OP_DIV;
        bus_if.a     = 32'd1;
        bus_if.b     = 32'd0;
      end
      tick();
      bus_if.start = 1'b0;
      if (bus_if.done) begin
        n_done++;
        if (first_done == 0) begin
          first_done = k;
          compare_result("midstart");
        end
      end
      if (bus_if.div_zero) check("midstart_dz", bus_if.div_zero, 1'b0);
    end
    check("midstart_ndone", n_done, 1);
    check("midstart_lat", first_done, LAT);

    // Back-to-back: second start issued in the done cycle of the first.
    run_op("b2b_first", OP_MULT, 32'd1000, 32'd1000, 32'h0, 32'd1000000);
    run_op_idle("b2b_second", OP_DIV, 32'd1000, 32'd33, 32'd10, 32'd30);

    // Reset in the middle of RUN: asynchronous clear, no done pulse.
    start_op(OP_MULT, 32'hFFFF_FFFF, 32'd12345);
    for (int k = 1; k < 15; k++) tick();
    check("mid_busy_pre", bus_if.busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", bus_if.busy, 1'b0);
    check("arst_hilo", {bus_if.hi, bus_if.lo}, '0);
    check("arst_state", dbg_state, IDLE);
    n_done = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus_if.done) n_done++;
    end
    reset = 1'b1;
    for (int k = 0; k < LAT + 5; k++) begin
      tick();
      if (bus_if.done) n_done++;
    end
    check("arst_nodone", n_done, 0);
    run_op_idle("div_100_7", OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14);

    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

- Parametrised iterative multiply/divide unit for the multicycle MIPS datapath.
- Sits beside the ALU, takes operands from the A and B registers, and writes the architectural HI/LO pair.
- The control unit drives it with a start/done handshake; it reports divide-by-zero for exception handling.
- Successor to the fixed 32-bit separate mult/div blocks:
  - width is generic;
  - signed and unsigned modes;
  - a busy flag so the control unit stalls in one wait state.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; must be ≥ 4 and even.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous reset, active-low (0 = reset)
- start  in  1  request; sampled only in IDLE
- op  in  2  operation: 00 MULT, 01 DIV, 10 MULTU, 11 DIVU
- a  in  WIDTH  multiplicand / dividend (RegA)
- b  in  WIDTH  multiplier / divisor (RegB)
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse: result valid
- div_zero  out  1  one-cycle pulse with done: divide with b == 0
- hi  out  WIDTH  HI register (upper product / remainder)
- lo  out  WIDTH  LO register (lower product / quotient)

## Operation
- States: IDLE, RUN, FIX. Iteration counter is clog2(WIDTH) + 1 bits.
- IDLE with start = 1:
  - Latch op.
  - Signed ops latch |a| and |b| plus result-sign bits; unsigned ops latch raw values.
  - Clear the accumulator and counter; go to RUN.
- Divide-by-zero: in IDLE, start with a divide op and b == 0:
  - stay in IDLE;
  - next edge: done = 1, div_zero = 1;
  - hi/lo unchanged.
- RUN, multiply: radix-2 shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle, WIDTH cycles.
- RUN, divide: restoring division, one quotient bit per cycle, WIDTH cycles. Partial remainder is WIDTH+1 bits.
- FIX: apply sign correction and load hi/lo; done = 1 next cycle; return to IDLE.
  - Multiply: negate the 2·WIDTH product if the operand signs differ.
  - Divide: quotient negated if the signs differ; remainder takes the dividend's sign.
- Signed overflow, most-negative value / −1: lo = most-negative value, hi = 0, no flag. This falls out of the magnitude algorithm and must not be special-cased away.
- start while busy: ignored, no queuing.
- a and b may change after the start edge without affecting the result.
- hi/lo change only at the FIX→IDLE edge; they hold between operations.

## Timing
- Reset (reset = 0, asynchronous):
  - state IDLE; busy = 0, done = 0, div_zero = 0, hi = 0, lo = 0;
  - the counter and accumulator are cleared.
- Reset mid-RUN aborts with no done pulse.
- With start sampled at edge E0:
  - busy = 1 after E0;
  - RUN occupies edges E1..E_WIDTH;
  - FIX happens at edge E_(WIDTH+1);
  - hi/lo/done update at E_(WIDTH+1); busy = 0 from the same edge.
- Latency is WIDTH+1 edges; for WIDTH = 32 this is 33 edges.
- done stays high exactly one cycle.
- A new start is accepted on the cycle done is high (back-to-back).
- Divide-by-zero: done and div_zero are high after E1; busy never asserts.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- UNSIGNED_MD_EN defined:
  - op[1] selects unsigned mode (MULTU/DIVU);
  - sign preprocessing and FIX negation are bypassed for unsigned ops.
- Undefined:
  - op[1] is ignored;
  - all operations are signed;
  - the unsigned bypass logic is not synthesised.

## Structure
- Shared package mult_div_pkg holds:
  - op encoding constants (OP_MULT, OP_DIV, OP_MULTU, OP_DIVU);
  - the state enum (IDLE, RUN, FIX).
- One sub-module is natural: md_step, a combinational single iteration.
  - Inputs: accumulator/partial remainder, operand, mode.
  - Outputs: next accumulator and quotient bit.
  - Instantiated once inside mult_div_unit.

## Test plan
- MULT, a = 7, b = 0xFFFFFFFD (−3): hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; done is high exactly 33 edges after start, then low.
- MULTU (macro on), a = b = 0xFFFFFFFF: hi = 0xFFFFFFFE, lo = 0x00000001. With the macro off, the same op yields hi = 0, lo = 1 (signed −1·−1).
- DIV, a = 0xFFFFFFF9 (−7), b = 2: lo = 0xFFFFFFFD (−3), hi = 0xFFFFFFFF (−1). DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- DIV, a = 5, b = 0, with hi/lo preloaded 0x11/0x22: done = div_zero = 1 one edge later; hi/lo are still 0x11/0x22; busy stays 0.
- start pulsed at edge 10 of a running MULT: no effect on that result, and exactly one done pulse. Back-to-back start on the done cycle yields a second correct result 33 edges later.
- Assert reset at RUN cycle 15: busy, hi, lo drop to 0 immediately, no done pulse. After release, a fresh DIV 100 / 7 gives lo = 14, hi = 2.
